// File: rtl/logic_cond_pipe.sv
// Two-stage pipelined logic / conditional-set unit with a valid/ready handshake.
// Compare ops turn the ALU's A-B difference and V/C flags into a 0/1 result and latch sticky {Z,N,V}.
module logic_cond_pipe #(
  parameter int WIDTH   = 32,
  parameter int OUT_REG = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             v_in,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       flags,
  output logic             illegal_op
);

  logic [WIDTH-1:0] s1_result_d;
  logic [2:0]       s1_flags_d;
  logic             s1_cmp_d;
  logic             s1_illegal_d;
  logic             zero_bit;
  logic             less_bit;
  logic             cmp_bit;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_result_q;
  logic [2:0]       s1_flags_q;
  logic             s1_cmp_q;
  logic             s1_illegal_q;

  logic             s1_adv;
  logic             in_ready_int;
  logic             in_fire;
  logic             fin_valid;
  logic [WIDTH-1:0] fin_result;
  logic [2:0]       fin_flags;
  logic             fin_cmp;
  logic             fin_illegal;
  logic [2:0]       flags_q;

  // Signed less-than is N^V because a carries the already-computed difference A-B.
  always_comb begin
    zero_bit     = (a == '0);
    less_bit     = a[WIDTH-1] ^ v_in;
    s1_result_d  = '0;
    s1_flags_d   = {zero_bit, a[WIDTH-1], v_in};
    s1_cmp_d     = 1'b1;
    s1_illegal_d = 1'b0;
    cmp_bit      = 1'b0;
    case (op)
      4'b0000: begin s1_result_d = a & b;    s1_cmp_d = 1'b0; end
      4'b0001: begin s1_result_d = a | b;    s1_cmp_d = 1'b0; end
      4'b0010: begin s1_result_d = a ^ b;    s1_cmp_d = 1'b0; end
      4'b0011: begin s1_result_d = ~(a | b); s1_cmp_d = 1'b0; end
      4'b1000: cmp_bit = zero_bit;
      4'b1001: cmp_bit = !zero_bit;
      4'b1010: cmp_bit = zero_bit | less_bit;
      4'b1011: cmp_bit = less_bit;
      4'b1100: cmp_bit = !less_bit;
      4'b1101: cmp_bit = !zero_bit & !less_bit;
      4'b1110: cmp_bit = !c_in;
      4'b1111: cmp_bit = c_in;
      default: begin s1_cmp_d = 1'b0; s1_illegal_d = 1'b1; end
    endcase
    if (s1_cmp_d) s1_result_d = {{(WIDTH-1){1'b0}}, cmp_bit};
  end

  assign in_ready = in_ready_int & !reset;
  assign in_fire  = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_result_q  <= '0;
      s1_flags_q   <= 3'b000;
      s1_cmp_q     <= 1'b0;
      s1_illegal_q <= 1'b0;
    end else if (in_fire) begin
      s1_valid_q   <= 1'b1;
      s1_result_q  <= s1_result_d;
      s1_flags_q   <= s1_flags_d;
      s1_cmp_q     <= s1_cmp_d;
      s1_illegal_q <= s1_illegal_d;
    end else if (s1_adv) begin
      s1_valid_q   <= 1'b0;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_result_q;
    logic [2:0]       s2_flags_q;
    logic             s2_cmp_q;
    logic             s2_illegal_q;
    logic             adv2;

    assign adv2         = !s2_valid_q | out_ready;
    assign s1_adv       = s1_valid_q & adv2;
    assign in_ready_int = !s1_valid_q | adv2;

    // Stage 2 only changes when empty or draining, so a stalled beat holds still.
    always_ff @(posedge clk) begin
      if (reset) begin
        s2_valid_q   <= 1'b0;
        s2_result_q  <= '0;
        s2_flags_q   <= 3'b000;
        s2_cmp_q     <= 1'b0;
        s2_illegal_q <= 1'b0;
      end else if (s1_adv) begin
        s2_valid_q   <= 1'b1;
        s2_result_q  <= s1_result_q;
        s2_flags_q   <= s1_flags_q;
        s2_cmp_q     <= s1_cmp_q;
        s2_illegal_q <= s1_illegal_q;
      end else if (out_ready) begin
        s2_valid_q   <= 1'b0;
      end
    end

    assign fin_valid   = s2_valid_q;
    assign fin_result  = s2_result_q;
    assign fin_flags   = s2_flags_q;
    assign fin_cmp     = s2_cmp_q;
    assign fin_illegal = s2_illegal_q;
  end else begin : g_bypass
    assign s1_adv       = s1_valid_q & out_ready;
    assign in_ready_int = !s1_valid_q | out_ready;
    assign fin_valid    = s1_valid_q;
    assign fin_result   = s1_result_q;
    assign fin_flags    = s1_flags_q;
    assign fin_cmp      = s1_cmp_q;
    assign fin_illegal  = s1_illegal_q;
  end

  // Sticky flags follow compares only, at the moment they are handed off.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 3'b000;
    end else if (fin_valid & out_ready & fin_cmp) begin
      flags_q <= fin_flags;
    end
  end

  assign out_valid  = fin_valid;
  assign out        = fin_result;
  assign flags      = flags_q;
  assign illegal_op = fin_valid & fin_illegal;

endmodule

// File: tb/tb_logic_cond_pipe.sv
// Directed bench for logic_cond_pipe (WIDTH=32, OUT_REG=1): each task drives one scenario
// and checks hand-computed results; inputs change and outputs are sampled 1 ns after posedge.
module tb_logic_cond_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        v_in;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [2:0]  flags;
  logic        illegal_op;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  t_op  [9];
  logic [31:0] t_a   [9];
  logic [31:0] t_b   [9];
  logic        t_v   [9];
  logic        t_c   [9];
  logic [31:0] t_exp [9];

  logic_cond_pipe #(.WIDTH(32), .OUT_REG(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .v_in(v_in), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .flags(flags), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input logic vv, input logic cc);
    in_valid = 1'b1;
    op = o; a = aa; b = bb; v_in = vv; c_in = cc;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    op = 4'b0000; a = '0; b = '0; v_in = 1'b0; c_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b1; idle();
    step(); step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_out: got %h expected 00000000", out); end
    n_checks++; if (flags !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 000", flags); end
    n_checks++; if (illegal_op !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_illegal: got %b expected 0", illegal_op); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    reset = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_and_latency();
    drive(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0);
    step(); idle();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL and_t1_valid: got %b expected 0", out_valid); end
    step();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL and_t2_valid: got %b expected 1", out_valid); end
    n_checks++; if (out !== 32'hF000_F000) begin n_fail++; $display("[TB] FAIL and_t2_out: got %h expected f000f000", out); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL and_t3_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_slt_flags();
    drive(4'b1011, 32'h8000_0000, 32'h0, 1'b0, 1'b0);
    step(); idle(); step();
    n_checks++; if (out !== 32'h0000_0001 || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL slt_out: got %h/%b expected 00000001/1", out, out_valid); end
    step();
    n_checks++; if (flags !== 3'b010) begin n_fail++; $display("[TB] FAIL slt_flags: got %b expected 010", flags); end
  endtask

  task automatic test_sgt_then_or();
    drive(4'b1101, 32'h0, 32'h0, 1'b0, 1'b0);
    step(); idle(); step();
    n_checks++; if (out !== 32'h0 || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL sgt_out: got %h/%b expected 00000000/1", out, out_valid); end
    step();
    n_checks++; if (flags !== 3'b100) begin n_fail++; $display("[TB] FAIL sgt_flags: got %b expected 100", flags); end
    drive(4'b0001, 32'h0000_0012, 32'h0000_0021, 1'b1, 1'b1);
    step(); idle(); step();
    n_checks++; if (out !== 32'h0000_0033) begin n_fail++; $display("[TB] FAIL or_out: got %h expected 00000033", out); end
    step();
    n_checks++; if (flags !== 3'b100) begin n_fail++; $display("[TB] FAIL or_flags_kept: got %b expected 100", flags); end
  endtask

  task automatic test_illegal();
    drive(4'b0101, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b1);
    step();
    drive(4'b0000, 32'h0000_FFFF, 32'h00FF_00FF, 1'b0, 1'b0);
    step(); idle();
    n_checks++; if (out !== 32'h0 || illegal_op !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL illegal_beat: got out=%h ill=%b v=%b expected 00000000/1/1", out, illegal_op, out_valid); end
    step();
    n_checks++; if (illegal_op !== 1'b0 || out !== 32'h0000_00FF) begin n_fail++; $display("[TB] FAIL after_illegal: got out=%h ill=%b expected 000000ff/0", out, illegal_op); end
    step();
    n_checks++; if (flags !== 3'b100) begin n_fail++; $display("[TB] FAIL illegal_flags_kept: got %b expected 100", flags); end
  endtask

  task automatic test_stream();
    t_op[0] = 4'b0010; t_a[0] = 32'hFFFF_0000; t_b[0] = 32'h0F0F_0F0F; t_v[0] = 0; t_c[0] = 0; t_exp[0] = 32'hF0F0_0F0F;
    t_op[1] = 4'b0011; t_a[1] = 32'h0F0F_0000; t_b[1] = 32'h0000_0F0F; t_v[1] = 0; t_c[1] = 0; t_exp[1] = 32'hF0F0_F0F0;
    t_op[2] = 4'b1000; t_a[2] = 32'h0000_0000; t_b[2] = 32'hFFFF_FFFF; t_v[2] = 0; t_c[2] = 0; t_exp[2] = 32'h1;
    t_op[3] = 4'b1001; t_a[3] = 32'h0000_0005; t_b[3] = 32'h0;         t_v[3] = 0; t_c[3] = 0; t_exp[3] = 32'h1;
    t_op[4] = 4'b1010; t_a[4] = 32'h0000_0001; t_b[4] = 32'h0;         t_v[4] = 0; t_c[4] = 1; t_exp[4] = 32'h0;
    t_op[5] = 4'b1010; t_a[5] = 32'hFFFF_FFFF; t_b[5] = 32'h0;         t_v[5] = 0; t_c[5] = 0; t_exp[5] = 32'h1;
    t_op[6] = 4'b1100; t_a[6] = 32'h8000_0000; t_b[6] = 32'h0;         t_v[6] = 1; t_c[6] = 0; t_exp[6] = 32'h1;
    t_op[7] = 4'b1110; t_a[7] = 32'h0000_0010; t_b[7] = 32'h0;         t_v[7] = 0; t_c[7] = 0; t_exp[7] = 32'h1;
    t_op[8] = 4'b1111; t_a[8] = 32'h7FFF_FFFF; t_b[8] = 32'h0;         t_v[8] = 1; t_c[8] = 0; t_exp[8] = 32'h0;
    for (int k = 0; k < 11; k++) begin
      if (k >= 2) begin
        n_checks++;
        if (out_valid !== 1'b1 || out !== t_exp[k-2]) begin
          n_fail++; $display("[TB] FAIL stream_%0d: got %h/%b expected %h/1", k-2, out, out_valid, t_exp[k-2]);
        end
      end
      if (k < 9) begin
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_ready_%0d: got %b expected 1", k, in_ready); end
        drive(t_op[k], t_a[k], t_b[k], t_v[k], t_c[k]);
      end else begin
        idle();
      end
      step();
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stream_drained: got %b expected 0", out_valid); end
    n_checks++; if (flags !== 3'b001) begin n_fail++; $display("[TB] FAIL stream_flags: got %b expected 001", flags); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(4'b0001, 32'h0, 32'h100, 1'b0, 1'b0);
    step();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_step1: got rdy=%b v=%b expected 1/0", in_ready, out_valid); end
    drive(4'b0001, 32'h1, 32'h100, 1'b0, 1'b0);
    step();
    drive(4'b0001, 32'h2, 32'h100, 1'b0, 1'b0);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_full_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_valid !== 1'b1 || out !== 32'h100) begin n_fail++; $display("[TB] FAIL bp_hold0: got %h/%b expected 00000100/1", out, out_valid); end
    step();
    n_checks++; if (in_ready !== 1'b0 || out !== 32'h100) begin n_fail++; $display("[TB] FAIL bp_stable: got rdy=%b out=%h expected 0/00000100", in_ready, out); end
    out_ready = 1'b1;
    step();
    drive(4'b0001, 32'h3, 32'h100, 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b1 || out !== 32'h101) begin n_fail++; $display("[TB] FAIL bp_res1: got %h/%b expected 00000101/1", out, out_valid); end
    step(); idle();
    n_checks++; if (out_valid !== 1'b1 || out !== 32'h102) begin n_fail++; $display("[TB] FAIL bp_res2: got %h/%b expected 00000102/1", out, out_valid); end
    step();
    n_checks++; if (out_valid !== 1'b1 || out !== 32'h103) begin n_fail++; $display("[TB] FAIL bp_res3: got %h/%b expected 00000103/1", out, out_valid); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    drive(4'b1000, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    drive(4'b1011, 32'h8000_0000, 32'h0, 1'b1, 1'b0);
    step();
    n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_full: got v=%b rdy=%b expected 1/0", out_valid, in_ready); end
    drive(4'b1001, 32'h5, 32'h0, 1'b0, 1'b0);
    reset = 1'b1; out_ready = 1'b1;
    step();
    idle();
    n_checks++; if (out_valid !== 1'b0 || flags !== 3'b000 || out !== 32'h0 || in_ready !== 1'b0) begin
      n_fail++; $display("[TB] FAIL mid_reset: got v=%b flags=%b out=%h rdy=%b expected 0/000/00000000/0", out_valid, flags, out, in_ready);
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_stale_%0d: got %b expected 0", k, out_valid); end
    end
    n_checks++; if (flags !== 3'b000) begin n_fail++; $display("[TB] FAIL mid_flags: got %b expected 000", flags); end
  endtask

  initial begin
    test_reset();
    test_and_latency();
    test_slt_flags();
    test_sgt_then_or();
    test_illegal();
    test_stream();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_cond_pipe.md
LOGIC_COND_PIPE -- requirements
Module: logic_cond_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width, legal range 2..64.
REQ-002 Parameter OUT_REG, default 1: 1 = registered stage-2 output; 0 = stage 2 bypassed, latency 1.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present on op/a/b/v_in/c_in.
REQ-006 in_ready  output  1  block accepts the request this cycle.
REQ-007 op  input  4  operation select, encoding in REQ-013.
REQ-008 a  input  WIDTH  logic operand A; for compare ops, the ALU difference result (A-B).
REQ-009 b  input  WIDTH  logic operand B; ignored for compare ops.
REQ-010 v_in / c_in  input  1 each  ALU overflow / ALU carry-out of A-B, used by compare ops only.
REQ-011 out_valid / out_ready  output / input  1 each  result handshake.
REQ-012 out  output  WIDTH; flags  output  3 ({Z,N,V} sticky); illegal_op  output  1.

Function
REQ-013 op encoding: 0000 AND, 0001 OR, 0010 XOR, 0011 NOR, 1000 SEQ, 1001 SNE, 1010 SLE, 1011 SLT, 1100 SGE, 1101 SGT, 1110 SLTU, 1111 SGEU; 0100-0111 illegal.
REQ-014 Compare terms: Z = (a==0), N = a[WIDTH-1], V = v_in; SEQ=Z, SNE=!Z, SLT=N^V, SGE=!(N^V), SLE=Z|(N^V), SGT=!Z&!(N^V), SLTU=!c_in, SGEU=c_in.
REQ-015 Compare result zero-extended to WIDTH: out = {WIDTH-1 zeros, bit}.
REQ-016 Logic ops are bitwise over full WIDTH; NOR = ~(a|b).
REQ-017 Request transfers when in_valid & in_ready; result transfers when out_valid & out_ready.
REQ-018 Stage 1 register (s1_valid, s1_result, s1_flags, s1_illegal) loads on input transfer.
REQ-019 OUT_REG=1: adv2 = !s2_valid | out_ready; s1 moves to s2 when s1_valid & adv2; in_ready = !s1_valid | adv2.
REQ-020 OUT_REG=1: latency 2 cycles from input transfer to out_valid; throughput 1 per cycle while out_ready=1.
REQ-021 OUT_REG=0: out/out_valid driven from s1; in_ready = !s1_valid | out_ready; latency 1.
REQ-022 While out_valid=1 and out_ready=0, out, flags and illegal_op SHALL hold stable; no request is dropped or duplicated.
REQ-023 Simultaneous output and input transfer in the same cycle SHALL be lossless (pipeline advances, new request enters s1).
REQ-024 flags register updates with {Z,N,V} of a compare op at the cycle that op leaves the final stage; logic and illegal ops leave flags unchanged.
REQ-025 Illegal op: out = 0, illegal_op = 1 alongside that result only, flags unchanged; the request still consumes one slot and is delivered in order.
REQ-026 in_ready and out_valid depend only on registered state and out_ready; in_valid does not combinationally affect in_ready.

Reset
REQ-027 While reset=1: s1_valid=s2_valid=0, out_valid=0, out=0, flags=3'b000, illegal_op=0, in_ready=0.
REQ-028 First cycle after reset deasserts: in_ready=1.
REQ-029 Reset asserted mid-operation discards all in-flight results; none appear on out after reset.
REQ-030 Reset has priority over any simultaneous transfer in the same cycle.

Verification
REQ-031 WIDTH=32, OUT_REG=1, out_ready=1: op=0000, a=0xF0F0_F0F0, b=0xFF00_FF00 at cycle t -> out=0xF000_F000, out_valid=1 at t+2.
REQ-032 op=1011, a=0x8000_0000, v_in=0 -> out=0x0000_0001; flags=3'b010 after delivery.
REQ-033 op=1101, a=0x0000_0000, v_in=0 -> out=0; flags=3'b100; then op=0001 -> flags still 3'b100.
REQ-034 Back-to-back 4 requests, out_ready=0 for 3 cycles -> in_ready=0 after 2 accepted; all 4 results delivered in order after release, none lost.
REQ-035 op=0101, any a/b -> out=0, illegal_op=1 for that beat only, flags unchanged.
REQ-036 Reset pulsed with s1 and s2 full -> out_valid=0 next cycle, flags=0, no stale result delivered.
